// File: rtl/node_tree_walker_if.sv
// Field-id / pop / resolved-node handshake bundle for node_tree_walker.
// The walker sits on the slave modport; the parser and consumer side sit on the master modport.
interface node_tree_walker_if #(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned NODE_W    = 6,
  parameter int unsigned MAX_DEPTH = 8
) ();
  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic [ID_W-1:0]    field_id_i;
  logic               field_id_valid_i;
  logic               field_id_rdy_o;
  logic               pop_valid_i;
  logic               pop_rdy_o;
  logic [NODE_W-1:0]  node_o;
  logic               node_leaf_o;
  logic               node_miss_o;
  logic [DEPTH_W-1:0] node_depth_o;
  logic               node_valid_o;
  logic               node_rdy_i;

  modport master (
    output field_id_i, field_id_valid_i, pop_valid_i, node_rdy_i,
    input  field_id_rdy_o, pop_rdy_o, node_o, node_leaf_o, node_miss_o,
           node_depth_o, node_valid_o
  );

  modport slave (
    input  field_id_i, field_id_valid_i, pop_valid_i, node_rdy_i,
    output field_id_rdy_o, pop_rdy_o, node_o, node_leaf_o, node_miss_o,
           node_depth_o, node_valid_o
  );
endinterface

// File: rtl/node_tree_walker.sv
// Run-time-programmable message-tree walker with a depth stack for sub-messages.
// Optional NODE_TREE_STATS_EN adds saturating hit/miss counters.
module node_tree_walker #(
  parameter int unsigned ID_W         = 8,
  parameter int unsigned NODE_W       = 6,
  parameter int unsigned MAX_CHILDREN = 4,
  parameter int unsigned MAX_DEPTH    = 8,
  parameter int unsigned SLOT_W       = $clog2(MAX_CHILDREN),
  parameter int unsigned DEPTH_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  node_tree_walker_if.slave        bus,
  input  logic                     cfg_we_i,
  input  logic [NODE_W+SLOT_W-1:0] cfg_addr_i,
  input  logic [ID_W+NODE_W+1:0]   cfg_data_i,
  output logic                     err_overflow_o,
  output logic                     err_underflow_o
`ifdef NODE_TREE_STATS_EN
  ,
  output logic [31:0]              hit_count_o,
  output logic [31:0]              miss_count_o
`endif
);

  localparam int unsigned ENTRIES = 2 ** (NODE_W + SLOT_W);
  localparam int unsigned SP_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]         state;
  logic [NODE_W-1:0]  cur_node;
  logic [DEPTH_W-1:0] depth;
  logic [NODE_W-1:0]  stack_q [MAX_DEPTH];
  logic [ID_W-1:0]    id_q;

  logic [ENTRIES-1:0] tbl_valid;
  logic               tbl_leaf  [ENTRIES];
  logic [NODE_W-1:0]  tbl_child [ENTRIES];
  logic [ID_W-1:0]    tbl_fid   [ENTRIES];

  logic               rd_valid [MAX_CHILDREN];
  logic               rd_leaf  [MAX_CHILDREN];
  logic [NODE_W-1:0]  rd_child [MAX_CHILDREN];
  logic [ID_W-1:0]    rd_fid   [MAX_CHILDREN];

  logic [NODE_W-1:0]  node_q;
  logic               leaf_q;
  logic               miss_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               valid_q;
  logic               push_q;

  logic               idle;
  logic               field_acc;
  logic               pop_acc;
  logic               out_hs;
  logic               at_top;
  logic               at_root;
  logic [DEPTH_W-1:0] depth_m1;
  logic [DEPTH_W-1:0] depth_p1;
  logic [SP_W-1:0]    sp_push;
  logic [SP_W-1:0]    sp_pop;

  logic               hit;
  logic               hit_leaf;
  logic [NODE_W-1:0]  hit_child;

  // Gated by reset so every output reads 0 while reset is held.
  assign idle                 = (state == S_IDLE) && reset_i;
  assign bus.pop_rdy_o        = idle;
  assign bus.field_id_rdy_o   = idle && !bus.pop_valid_i;
  assign field_acc            = bus.field_id_valid_i && bus.field_id_rdy_o;
  assign pop_acc              = bus.pop_valid_i && bus.pop_rdy_o;
  assign out_hs               = (state == S_OUT) && bus.node_rdy_i;

  assign at_top   = (depth == DEPTH_MAX);
  assign at_root  = (depth == '0);
  assign depth_m1 = depth - DEPTH_ONE;
  assign depth_p1 = depth + DEPTH_ONE;
  assign sp_push  = depth[SP_W-1:0];
  assign sp_pop   = depth_m1[SP_W-1:0];

  assign bus.node_o       = node_q;
  assign bus.node_leaf_o  = leaf_q;
  assign bus.node_miss_o  = miss_q;
  assign bus.node_depth_o = depth_q;
  assign bus.node_valid_o = valid_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tbl_valid <= '0;
    end else if (cfg_we_i) begin
      tbl_valid[cfg_addr_i] <= cfg_data_i[ID_W+NODE_W+1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (cfg_we_i) begin
      tbl_leaf[cfg_addr_i]  <= cfg_data_i[ID_W+NODE_W];
      tbl_child[cfg_addr_i] <= cfg_data_i[ID_W+NODE_W-1:ID_W];
      tbl_fid[cfg_addr_i]   <= cfg_data_i[ID_W-1:0];
    end
  end

  // Snapshot of cur_node's children; a same-cycle cfg write lands after this read.
  always_ff @(posedge clk_i) begin
    if (field_acc) begin
      id_q <= bus.field_id_i;
    end
    if (state == S_RD) begin
      for (int unsigned s = 0; s < MAX_CHILDREN; s++) begin
        rd_valid[s] <= tbl_valid[{cur_node, SLOT_W'(s)}];
        rd_leaf[s]  <= tbl_leaf[{cur_node, SLOT_W'(s)}];
        rd_child[s] <= tbl_child[{cur_node, SLOT_W'(s)}];
        rd_fid[s]   <= tbl_fid[{cur_node, SLOT_W'(s)}];
      end
    end
  end

  always_comb begin
    hit       = 1'b0;
    hit_leaf  = 1'b0;
    hit_child = '0;
    for (int unsigned s = 0; s < MAX_CHILDREN; s++) begin
      if (!hit && rd_valid[s] && (rd_fid[s] == id_q)) begin
        hit       = 1'b1;
        hit_leaf  = rd_leaf[s];
        hit_child = rd_child[s];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (out_hs && push_q && !at_top) begin
      stack_q[sp_push] <= cur_node;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state           <= S_IDLE;
      cur_node        <= '0;
      depth           <= '0;
      node_q          <= '0;
      leaf_q          <= 1'b0;
      miss_q          <= 1'b0;
      depth_q         <= '0;
      valid_q         <= 1'b0;
      push_q          <= 1'b0;
      err_overflow_o  <= 1'b0;
      err_underflow_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_acc) begin
            if (at_root) begin
              err_underflow_o <= 1'b1;
            end else begin
              cur_node <= stack_q[sp_pop];
              depth    <= depth_m1;
            end
          end else if (field_acc) begin
            state <= S_RD;
          end
        end
        S_RD: state <= S_CMP;
        S_CMP: begin
          node_q  <= hit ? hit_child : '0;
          leaf_q  <= hit && hit_leaf;
          miss_q  <= !hit;
          depth_q <= (hit && !hit_leaf && !at_top) ? depth_p1 : depth;
          push_q  <= hit && !hit_leaf;
          valid_q <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (bus.node_rdy_i) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
            if (push_q) begin
              if (at_top) begin
                err_overflow_o <= 1'b1;
              end else begin
                cur_node <= node_q;
                depth    <= depth_p1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NODE_TREE_STATS_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (out_hs) begin
      if (miss_q) begin
        if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
      end else begin
        if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/node_tree_walker.md
Name: node_tree_walker

Overview:
Parametrised successor of the fixed-tree node lookup. Walks a run-time-programmable message tree: each incoming field id is matched against the children of the current node and the matched node is emitted. Descending into a sub-message pushes the parent onto a depth stack; an explicit pop returns to it. Sits between the field-id parser and the node consumer in the decode pipeline.

Parameters:
ID_W, 8, field identifier width
NODE_W, 6, node index width (2**NODE_W nodes; node 0 is root)
MAX_CHILDREN, 4, child slots per node (power of 2)
MAX_DEPTH, 8, depth-stack entries
SLOT_W, $clog2(MAX_CHILDREN), derived, do not override
DEPTH_W, $clog2(MAX_DEPTH+1), derived, do not override

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-low
field_id_i  in  ID_W  field id to resolve
field_id_valid_i  in  1  field id valid
field_id_rdy_o  out  1  field id accepted when valid&rdy
pop_valid_i  in  1  end of current sub-message; return to parent
pop_rdy_o  out  1  pop accepted when valid&rdy
node_o  out  NODE_W  resolved node index (0 on miss)
node_leaf_o  out  1  resolved node is a leaf
node_miss_o  out  1  no child matched
node_depth_o  out  DEPTH_W  depth of current node after this result
node_valid_o  out  1  result valid
node_rdy_i  in  1  consumer ready
cfg_we_i  in  1  table write strobe
cfg_addr_i  in  NODE_W+SLOT_W  {parent, slot}
cfg_data_i  in  ID_W+NODE_W+2  {valid, leaf, child, field_id}
err_overflow_o  out  1  sticky: push attempted at MAX_DEPTH
err_underflow_o  out  1  sticky: pop attempted at depth 0

Behaviour:
- Reset: all outputs 0; state IDLE; cur_node=0; depth=0; all table valid bits cleared (valid bits are flops; remaining entry fields need no reset).
- States: IDLE -> RD -> CMP -> OUT -> IDLE.
- IDLE: field_id_rdy_o = ~pop_valid_i; pop_rdy_o = 1. Pop has priority when both valid. Both rdys 0 in all other states.
- Field accepted at edge T: RD latches id and all MAX_CHILDREN entries of cur_node; CMP selects lowest slot with valid=1 and matching field_id; results register and node_valid_o rises at T+2 (OUT).
- OUT: node_valid_o and all node_* held stable until node_rdy_i; on handshake, pointer update then IDLE. No new lookup starts before the previous result is consumed.
- Pointer update on handshake: hit, leaf=0 -> push cur_node, cur_node<=child, depth+1; hit, leaf=1 -> no change; miss -> no change. Push at depth==MAX_DEPTH -> no push, no pointer change, err_overflow_o set.
- node_depth_o reports depth after the update (e.g. root child non-leaf -> 1).
- Pop accepted in IDLE: depth>0 -> cur_node<=stack top, depth-1, one cycle; depth==0 -> ignored, err_underflow_o set.
- Sticky errors clear only on reset.
- cfg writes are accepted every cycle. A write to an entry in the same cycle as RD latches it yields the old value; later lookups see the new value.
- Reset asserted mid-lookup: result dropped; state, pointer and table valid bits return to reset values.

Optional Feature:
NODE_TREE_STATS_EN: adds outputs hit_count_o[31:0] and miss_count_o[31:0], incremented on each OUT handshake (hit or miss respectively), saturating at all-ones, cleared on reset. When the macro is undefined, these ports and counters do not exist.

Test Plan:
- Reset, program {0,0}={1,0,5,0x11}; send 0x11 -> node_valid_o exactly 2 cycles after accept, node_o=5, leaf=0, depth=1; next lookup uses node 5's children.
- At node 5, program {5,2}={1,1,9,0x22}; send 0x22 -> node_o=9, leaf=1, depth stays 1; send 0x33 -> miss=1, node_o=0, pointer unchanged.
- Hold node_rdy_i=0 for 5 cycles in OUT -> outputs stable, field_id_rdy_o=0; release -> one handshake, return to IDLE.
- pop_valid_i and field_id_valid_i asserted together at depth 1 -> pop taken first, depth 0; field then resolves at root; a further pop at depth 0 sets err_underflow_o.
- Chain MAX_DEPTH+1 non-leaf descents -> depth saturates at 8, err_overflow_o=1, node_o still reports matched child.
- Assert reset_i low during RD -> no node_valid_o, depth=0, prior table entries read as miss.
